// File: rtl/ultrasonic_ranger_pkg.sv
// rtl/ultrasonic_ranger_pkg.sv - ranger FSM states, 100 MHz timing defaults, channel-index width helper
package ranger_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    HOLDOFF
  } state_e;

  localparam int DEF_NUM_CH         = 2;
  localparam int DEF_CNT_W          = 32;
  localparam int DEF_TRIG_CYCLES    = 1000;
  localparam int DEF_TIMEOUT_CYCLES = 3000000;
  localparam int DEF_HOLDOFF_CYCLES = 6000000;
  localparam int DEF_NEAR_CYCLES    = 294117;
  localparam int DEF_HYST_CYCLES    = 29412;

  // A single-channel build still needs a one-bit channel field.
  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ultrasonic_ranger_if.sv
// rtl/ultrasonic_ranger_if.sv - sensor pins and distance result bus of the ranger
interface ranger_if
  import ranger_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W
);
  localparam int CH_W = ch_width(NUM_CH);

  logic              enable;
  logic [NUM_CH-1:0] echo;
  logic [NUM_CH-1:0] trigger;
  logic [NUM_CH-1:0] is_crash;
  logic              dist_valid;
  logic [CH_W-1:0]   dist_ch;
  logic [CNT_W-1:0]  dist_cycles;
  logic              dist_timeout;

  modport master (
    input  enable, echo,
    output trigger, is_crash, dist_valid, dist_ch, dist_cycles, dist_timeout
  );

  modport slave (
    output enable, echo,
    input  trigger, is_crash, dist_valid, dist_ch, dist_cycles, dist_timeout
  );
endinterface

// File: rtl/ultrasonic_ranger_echo_sync.sv
// rtl/ultrasonic_ranger_echo_sync.sv - two-flop echo synchroniser with rise/fall pulses
module echo_sync (
  input  logic clk,
  input  logic rst,
  input  logic echo_i,
  output logic rise_o,
  output logic fall_o
);
  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= echo_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;
endmodule

// File: rtl/ultrasonic_ranger.sv
// rtl/ultrasonic_ranger.sv - round-robin ultrasonic ranger with timeout, holdoff and crash hysteresis
module ultrasonic_ranger
  import ranger_pkg::*;
#(
  parameter int NUM_CH         = DEF_NUM_CH,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
  parameter int NEAR_CYCLES    = DEF_NEAR_CYCLES,
  parameter int HYST_CYCLES    = DEF_HYST_CYCLES
) (
  input  logic     clk,
  input  logic     rst,
  ranger_if.master bus
);
  localparam int CH_W = ch_width(NUM_CH);

  localparam logic [CNT_W-1:0] ONE          = CNT_W'(1);
  localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C    = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] HOLDOFF_LAST = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] NEAR_C       = CNT_W'(NEAR_CYCLES);
  localparam logic [CNT_W-1:0] FAR_C        = CNT_W'(NEAR_CYCLES + HYST_CYCLES);
  localparam logic [CH_W-1:0]  LAST_CH      = CH_W'(NUM_CH - 1);
  localparam logic [CH_W-1:0]  CH_ONE       = CH_W'(1);

  if (NUM_CH < 1 || TRIG_CYCLES < 1 || HOLDOFF_CYCLES < 1 || TIMEOUT_CYCLES < 1 ||
      (longint'(TIMEOUT_CYCLES) >> CNT_W) != 0 ||
      (longint'(HOLDOFF_CYCLES) >> CNT_W) != 0) begin : g_bad_params
    $error("ultrasonic_ranger: counter width too small or timing parameter out of range");
  end

  logic [NUM_CH-1:0] rise, fall;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_sync
    echo_sync u_sync (
      .clk    (clk),
      .rst    (rst),
      .echo_i (bus.echo[i]),
      .rise_o (rise[i]),
      .fall_o (fall[i])
    );
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [NUM_CH-1:0] trig_q, trig_d;
  logic [NUM_CH-1:0] crash_q, crash_d;
  logic              dist_valid_q, dist_timeout_q;
  logic [CH_W-1:0]   dist_ch_q;
  logic [CNT_W-1:0]  dist_cycles_q;
  logic              rep_valid, rep_timeout;
  logic [CNT_W-1:0]  rep_width;

  assign cnt_inc = cnt_q + ONE;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ch_d        = ch_q;
    rep_valid   = 1'b0;
    rep_timeout = 1'b0;
    rep_width   = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.enable) begin
          state_d = TRIG;
          cnt_d   = '0;
        end
      end
      TRIG: begin
        if (cnt_q == TRIG_LAST) begin
          state_d = WAIT_RISE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      // Only a fresh edge counts: a line already high on entry never produced a rise here.
      WAIT_RISE: begin
        if (rise[ch_q]) begin
          state_d = MEASURE;
          cnt_d   = ONE;
        end else if (cnt_inc == TIMEOUT_C) begin
          rep_valid   = 1'b1;
          rep_timeout = 1'b1;
          state_d     = HOLDOFF;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      MEASURE: begin
        if (fall[ch_q]) begin
          rep_valid = 1'b1;
          rep_width = cnt_q;
          state_d   = HOLDOFF;
          cnt_d     = '0;
        end else if (cnt_q == TIMEOUT_C) begin
          rep_valid   = 1'b1;
          rep_timeout = 1'b1;
          state_d     = HOLDOFF;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HOLDOFF: begin
        if (cnt_q == HOLDOFF_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          ch_d    = (ch_q == LAST_CH) ? '0 : ch_q + CH_ONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Widths between near and far keep the previous flag so it does not chatter.
  always_comb begin
    crash_d = crash_q;
    if (rep_valid) begin
      if (rep_timeout) begin
        crash_d[ch_q] = 1'b0;
      end else if (rep_width <= NEAR_C) begin
        crash_d[ch_q] = 1'b1;
      end else if (rep_width > FAR_C) begin
        crash_d[ch_q] = 1'b0;
      end
    end
  end

  always_comb begin
    trig_d = '0;
    if (state_d == TRIG) begin
      trig_d[ch_d] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      ch_q           <= '0;
      trig_q         <= '0;
      crash_q        <= '0;
      dist_valid_q   <= 1'b0;
      dist_timeout_q <= 1'b0;
      dist_ch_q      <= '0;
      dist_cycles_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ch_q         <= ch_d;
      trig_q       <= trig_d;
      crash_q      <= crash_d;
      dist_valid_q <= rep_valid;
      if (rep_valid) begin
        dist_ch_q      <= ch_q;
        dist_cycles_q  <= rep_width;
        dist_timeout_q <= rep_timeout;
      end
    end
  end

  assign bus.trigger      = trig_q;
  assign bus.is_crash     = crash_q;
  assign bus.dist_valid   = dist_valid_q;
  assign bus.dist_ch      = dist_ch_q;
  assign bus.dist_cycles  = dist_cycles_q;
  assign bus.dist_timeout = dist_timeout_q;
endmodule

// File: tb/tb_ultrasonic_ranger.sv
// tb/tb_ultrasonic_ranger.sv - scoreboard bench for ultrasonic_ranger
module tb_ultrasonic_ranger;
  localparam int T_TRIG    = 10;
  localparam int T_TIMEOUT = 200;
  localparam int T_HOLDOFF = 20;
  localparam int T_NEAR    = 50;
  localparam int T_HYST    = 10;

  typedef struct {
    int         ch;
    int         width;
    bit         to;
    logic [1:0] crash;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  logic [1:0] crash_m = 2'b00;

  always #5 clk = ~clk;

  ranger_if #(.NUM_CH(2), .CNT_W(32)) rif ();

  ultrasonic_ranger #(
    .NUM_CH         (2),
    .CNT_W          (32),
    .TRIG_CYCLES    (T_TRIG),
    .TIMEOUT_CYCLES (T_TIMEOUT),
    .HOLDOFF_CYCLES (T_HOLDOFF),
    .NEAR_CYCLES    (T_NEAR),
    .HYST_CYCLES    (T_HYST)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (rif)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    int   d;
    if (rif.dist_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_report", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("dist_ch", rif.dist_ch, e.ch);
        chk("dist_timeout", rif.dist_timeout, e.to);
        if (e.to) begin
          chk("dist_cycles_timeout", rif.dist_cycles, 0);
        end else begin
          d = int'(rif.dist_cycles) - e.width;
          chk($sformatf("width_within_1(got %0d want %0d)", rif.dist_cycles, e.width),
              (d >= -1 && d <= 1), 1);
        end
        chk("is_crash", rif.is_crash, e.crash);
      end
    end
  end

  task automatic wait_trig(input int ch, input bit drop_en);
    int n;
    logic [1:0] oh;
    oh = 2'b01 << ch;
    n = 0;
    while (rif.trigger == 2'b00 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("trig_seen", (n < 3000), 1);
    chk("trig_ch", rif.trigger, oh);
    n = 0;
    while (rif.trigger != 2'b00 && n < 100) begin
      if (drop_en && n == 3) rif.enable = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    chk("trig_len", n, T_TRIG);
  endtask

  // width < 0: echo never driven by this ping
  task automatic ping(input int ch, input int width, input bit drop_en);
    exp_t e;
    int n;
    wait_trig(ch, drop_en);
    e.ch    = ch;
    e.to    = (width < 0 || width > T_TIMEOUT);
    e.width = e.to ? 0 : width;
    if (e.to) crash_m[ch] = 1'b0;
    else if (width <= T_NEAR) crash_m[ch] = 1'b1;
    else if (width > T_NEAR + T_HYST) crash_m[ch] = 1'b0;
    e.crash = crash_m;
    exp_q.push_back(e);
    repeat (5) @(posedge clk);
    #1;
    if (width > 0) begin
      fork
        begin
          automatic int cc = ch;
          automatic int ww = width;
          rif.echo[cc] = 1'b1;
          repeat (ww) @(posedge clk);
          #1 rif.echo[cc] = 1'b0;
        end
      join_none
    end
    n = 0;
    while (exp_q.size() != 0 && n < 800) begin
      @(posedge clk); #1;
      n++;
    end
    chk("report_seen", exp_q.size(), 0);
  endtask

  initial begin
    int any;
    rst        = 1'b1;
    rif.enable = 1'b0;
    rif.echo   = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_trigger", rif.trigger, 0);
    chk("reset_is_crash", rif.is_crash, 0);
    chk("reset_dist_valid", rif.dist_valid, 0);
    chk("reset_dist_ch", rif.dist_ch, 0);
    chk("reset_dist_cycles", rif.dist_cycles, 0);
    chk("reset_dist_timeout", rif.dist_timeout, 0);
    rst        = 1'b0;
    rif.enable = 1'b1;

    ping(0, 40, 0);
    ping(1, -1, 0);
    ping(0, 55, 0);
    ping(1, -1, 0);
    ping(0, 61, 0);
    ping(1, 30, 0);
    ping(0, 50, 0);
    ping(1, -1, 0);
    ping(0, 300, 0);
    ping(1, -1, 0);
    rif.echo[0] = 1'b1;
    ping(0, -1, 0);
    rif.echo[0] = 1'b0;
    ping(1, 20, 0);

    // reset while channel 0 is mid-measurement
    wait_trig(0, 0);
    repeat (5) @(posedge clk);
    #1 rif.echo[0] = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rst         = 1'b1;
    rif.echo[0] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_trigger", rif.trigger, 0);
    chk("rst_is_crash", rif.is_crash, 0);
    chk("rst_dist_valid", rif.dist_valid, 0);
    chk("rst_dist_ch", rif.dist_ch, 0);
    chk("rst_dist_cycles", rif.dist_cycles, 0);
    chk("rst_dist_timeout", rif.dist_timeout, 0);
    crash_m = 2'b00;

    ping(0, 45, 0);
    ping(1, 35, 1);

    any = 0;
    repeat (150) begin
      @(posedge clk); #1;
      if (rif.trigger != 2'b00) any = 1;
    end
    chk("idle_no_trigger", any, 0);
    chk("idle_no_pending", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
